// File: rtl/wb_stream_bridge.sv
// wb_stream_bridge
//   Wishbone slave that bridges bus accesses onto val/rdy streams.
//   - N_CH outbound FIFOs are fed by word writes at BASE_ADDR + 4*i. A read
//     at the same address returns that FIFO's fill count.
//   - One inbound FIFO is filled from in_msg/in_val and drained by reads
//     at BASE_ADDR + 0x100.
//   - BASE_ADDR + 0x104 is a read-only status word:
//       bit i     out FIFO i full
//       bit 16    inbound non-empty
//       [31:24]   inbound count
//   - An access that cannot complete (push to a full FIFO, pop of an empty
//     one) is wait-stated until it can complete or the master drops the
//     request.
//   Optional macro WB_STREAM_BRIDGE_TIMEOUT_EN: when defined, a wait-state
//   that lasts TIMEOUT_CYC cycles ends with a one-cycle wbs_err_o.
//
// Ports
//   wb_clk_i, wb_rst_ni                clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/adr_i   Wishbone request (sel ignored)
//   wbs_dat_i                          Wishbone write data
//   wbs_ack_o, wbs_err_o, wbs_dat_o    registered response
//   out_msg/out_val/out_rdy            outbound streams, channel i in
//                                      out_msg[32i+31:32i]
//   in_msg/in_val/in_rdy               inbound stream
module wb_stream_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [DATA_W-1:0]        wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [DATA_W-1:0]        wbs_dat_o,
    output logic [N_CH*DATA_W-1:0]   out_msg,
    output logic [N_CH-1:0]          out_val,
    input  logic [N_CH-1:0]          out_rdy,
    input  logic [DATA_W-1:0]        in_msg,
    input  logic                     in_val,
    output logic                     in_rdy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

    state_t state, state_nxt;
    logic   req;
    logic   op_fire;     // the pending access completes on this edge
    logic   can_do;

    // ---------------------------------------------------------------- decode
    logic [31:0] adr_off;
    logic        is_ch, is_in, is_stat;
    logic [3:0]  ch_sel;

    assign req     = wbs_stb_i & wbs_cyc_i;
    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out
    // of range and decode as "other".
    assign adr_off = {wbs_adr_i[31:2], 2'b00} - BASE_ADDR;
    assign is_ch   = adr_off < 32'(4 * N_CH);
    assign ch_sel  = adr_off[5:2];
    assign is_in   = adr_off == 32'h0000_0100;
    assign is_stat = adr_off == 32'h0000_0104;

    logic unused_bits;
    assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

    // --------------------------------------------------------- outbound FIFOs
    logic [N_CH-1:0]    out_full;
    logic [N_CH*CW-1:0] out_cnt_flat;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]     wp, rp;
        logic [CW-1:0]     cnt;
        logic              push, pop;

        assign push = op_fire & wbs_we_i & is_ch & (ch_sel == 4'(g));
        assign pop  = out_val[g] & out_rdy[g];

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (push) mem[wp] <= wbs_dat_i;
        end

        assign out_val[g]                     = cnt != '0;
        assign out_full[g]                    = cnt == CW'(FIFO_DEPTH);
        assign out_cnt_flat[g*CW +: CW]       = cnt;
        // Gate the head so unwritten storage never leaks onto the port.
        assign out_msg[g*DATA_W +: DATA_W]    = out_val[g] ? mem[rp] : '0;
    end

    logic [CW-1:0] sel_cnt;
    logic          sel_full;

    always_comb begin
        sel_cnt  = '0;
        sel_full = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                sel_cnt  = out_cnt_flat[i*CW +: CW];
                sel_full = out_full[i];
            end
        end
    end

    // ----------------------------------------------------------- inbound FIFO
    logic [DATA_W-1:0] in_mem [FIFO_DEPTH];
    logic [AW-1:0]     in_wp, in_rp;
    logic [CW-1:0]     in_cnt;
    logic              in_push, in_pop;

    assign in_rdy  = wb_rst_ni & (in_cnt != CW'(FIFO_DEPTH));
    assign in_push = in_val & in_rdy;
    assign in_pop  = op_fire & ~wbs_we_i & is_in;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            in_wp  <= '0;
            in_rp  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + 1'b1;
            if (in_pop)  in_rp <= in_rp + 1'b1;
            if (in_push != in_pop) in_cnt <= in_push ? in_cnt + 1'b1 : in_cnt - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (in_push) in_mem[in_wp] <= in_msg;
    end

    // ------------------------------------------------- completion / read data
    // Full/empty come from registered counts only, so a pop on the same edge
    // never lets a stalled push through early.
    always_comb begin
        can_do = 1'b1;
        if (is_ch && wbs_we_i)
            can_do = ~sel_full;
        else if (is_in && !wbs_we_i)
            can_do = in_cnt != '0;
    end

    logic [DATA_W-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (is_ch) begin
            rd_data[CW-1:0] = sel_cnt;
        end else if (is_in) begin
            rd_data = in_mem[in_rp];
        end else if (is_stat) begin
            rd_data[N_CH-1:0] = out_full;
            rd_data[16]       = in_cnt != '0;
            rd_data[24 +: CW] = in_cnt;
        end
    end

    // ------------------------------------------------------------------ FSM
`ifdef WB_STREAM_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        wait_expired;

    // Zero everywhere outside WAIT, so it is clear on every entry to WAIT.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign wait_expired = wait_cnt >= 16'(TIMEOUT_CYC - 1);
`else
    logic        wait_expired;
    logic [31:0] unused_timeout;

    assign wait_expired   = 1'b0;
    assign unused_timeout = TIMEOUT_CYC;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (can_do) begin
                        op_fire   = 1'b1;
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (can_do) begin
                    op_fire   = 1'b1;
                    state_nxt = S_ACK;
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- response
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            wbs_dat_o <= '0;
        else if (op_fire)
            wbs_dat_o <= rd_data;
    end

    assign wbs_ack_o = state == S_ACK;
`ifdef WB_STREAM_BRIDGE_TIMEOUT_EN
    assign wbs_err_o = state == S_ERR;
`else
    assign wbs_err_o = 1'b0;
`endif

endmodule
